// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: effective-address generation, data-memory strobes,
// one-cycle load-latency absorption and a valid/ready result register toward writeback.
module mem_access_stage #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 7,
    parameter int unsigned RW = 3
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          exValid,
    output logic          exReady,
    input  logic          exIsLoad,
    input  logic          exIsStore,
    input  logic          exWe,
    input  logic [DW-1:0] exBase,
    input  logic [DW-1:0] exOffset,
    input  logic [DW-1:0] exStoreData,
    input  logic [DW-1:0] exAluResult,
    input  logic [RW-1:0] exRd,
    output logic [AW-1:0] lineNumber,
    output logic [DW-1:0] memIn,
    output logic          memRead,
    output logic          memWrite,
    input  logic [DW-1:0] memOut,
    output logic          wbValid,
    input  logic          wbReady,
    output logic [DW-1:0] wbData,
    output logic [RW-1:0] wbRd,
    output logic          wbWe,
    output logic          addrFault
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t        state;
    state_t        stateNext;
    logic [DW-1:0] ea;
    logic          isMemOp;
    logic          fault;
    logic          acc;
    logic          wbValidNext;
    logic          wbWeNext;
    logic          addrFaultNext;
    logic [DW-1:0] wbDataNext;
    logic [RW-1:0] wbRdNext;

    // Address path and strobes are combinational so a store lands on its accept edge.
    assign ea         = exBase + exOffset;
    assign lineNumber = ea[AW-1:0];
    assign memIn      = exStoreData;
    assign isMemOp    = exIsLoad || exIsStore;
    assign fault      = isMemOp && ((ea[DW-1:AW] != '0) || (exIsLoad && exIsStore));
    // Gating with rstN keeps both strobes low while reset is held.
    assign exReady    = rstN && (state == IDLE) && (!wbValid || wbReady);
    assign acc        = exValid && exReady;
    assign memWrite   = acc && exIsStore && !fault;
    assign memRead    = acc && exIsLoad && !fault;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            wbValid   <= 1'b0;
            wbWe      <= 1'b0;
            addrFault <= 1'b0;
            wbData    <= '0;
            wbRd      <= '0;
        end else begin
            state     <= stateNext;
            wbValid   <= wbValidNext;
            wbWe      <= wbWeNext;
            addrFault <= addrFaultNext;
            wbData    <= wbDataNext;
            wbRd      <= wbRdNext;
        end
    end

    // Next state and result register; a new accept overwrites a result draining this cycle.
    always_comb begin
        stateNext     = state;
        wbValidNext   = wbValid;
        wbWeNext      = wbWe;
        addrFaultNext = addrFault;
        wbDataNext    = wbData;
        wbRdNext      = wbRd;
        if (wbValid && wbReady) begin
            wbValidNext = 1'b0;
        end
        unique case (state)
            IDLE: begin
                if (acc) begin
                    wbRdNext = exRd;
                    if (fault) begin
                        wbValidNext   = 1'b1;
                        wbDataNext    = '0;
                        wbWeNext      = 1'b0;
                        addrFaultNext = 1'b1;
                    end else if (exIsLoad) begin
                        stateNext     = LOAD_WAIT;
                        wbValidNext   = 1'b0;
                        addrFaultNext = 1'b0;
                    end else if (exIsStore) begin
                        wbValidNext   = 1'b1;
                        wbDataNext    = exStoreData;
                        wbWeNext      = 1'b0;
                        addrFaultNext = 1'b0;
                    end else begin
                        wbValidNext   = 1'b1;
                        wbDataNext    = exAluResult;
                        wbWeNext      = exWe;
                        addrFaultNext = 1'b0;
                    end
                end
            end
            LOAD_WAIT: begin
                stateNext   = IDLE;
                wbValidNext = 1'b1;
                wbDataNext  = memOut;
                wbWeNext    = 1'b1;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule
